// File: rtl/rdout_dpram_writer_pkg.sv
// Shared types and constants for the direct-readout DPRAM writer.
// Holds the FSM state encoding, DPRAM geometry and dpram_mode values.
package rdout_dpram_writer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_HANDOFF   = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  localparam int DPRAM_DEPTH    = 1024;
  // dpram_len counts 16-bit words; the DPRAM is written in 32-bit words.
  localparam int LEN_UNIT_SHIFT = 1;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_PACK   = 1'b1;

endpackage

// File: rtl/rdout_dpram_writer.sv
// Writer end of the direct-readout DPRAM handshake: drains waveform events from
// a show-ahead FIFO into the DPRAM, then hands the buffer to the xdom reader.
module rdout_dpram_writer
  import rdout_dpram_writer_pkg::*;
#(
  parameter int ADDR_W      = $clog2(DPRAM_DEPTH),
  parameter int MAX_EVT_WDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              dpram_mode,
  input  logic [31:0]       src_data,
  input  logic              src_last,
  input  logic              src_empty,
  output logic              src_rdreq,
  output logic              rdout_dpram_wren,
  output logic [ADDR_W-1:0] rdout_dpram_wr_addr,
  output logic [31:0]       rdout_dpram_data,
  output logic              rdout_dpram_run,
  output logic [15:0]       dpram_len,
  input  logic              dpram_busy,
  output logic              trunc_err,
  input  logic              err_clr,
  output logic [15:0]       evt_cnt,
  output logic              idle
);

  // Pointer is one bit wider than the address so "buffer full" is representable.
  localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t          state, next_state;
  logic [ADDR_W:0] wr_ptr, ptr_after, space_after;
  logic [15:0]     evt_in_buf;
  logic            at_boundary;
  logic            pop, full, pack_continue, fill_entry;

  assign full          = (wr_ptr == PTR_FULL);
  assign ptr_after     = full ? wr_ptr : wr_ptr + 1'b1;
  assign space_after   = PTR_FULL - ptr_after;
  // In pack mode an event end only keeps filling if a worst-case event still fits.
  assign pack_continue = (dpram_mode == MODE_PACK) && enable &&
                         (int'(space_after) >= MAX_EVT_WDS);
  assign fill_entry    = (state == S_IDLE) && (next_state == S_FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    next_state = state;
    case (state)
      S_IDLE:      if (enable && !src_empty) next_state = S_FILL;
      S_FILL: begin
        if (pop && src_last && !pack_continue) next_state = S_HANDOFF;
        else if (!pop && at_boundary)          next_state = S_HANDOFF;
      end
      S_HANDOFF:   next_state = S_WAIT_BUSY;
      S_WAIT_BUSY: if (dpram_busy)  next_state = S_WAIT_DONE;
      S_WAIT_DONE: if (!dpram_busy) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    src_rdreq = 1'b0;
    idle      = 1'b0;
    if (state == S_FILL && !src_empty) src_rdreq = 1'b1;
    if (state == S_IDLE)               idle      = 1'b1;
  end

  assign pop = src_rdreq;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr              <= '0;
      evt_in_buf          <= '0;
      at_boundary         <= 1'b0;
      rdout_dpram_wren    <= 1'b0;
      rdout_dpram_wr_addr <= '0;
      rdout_dpram_data    <= '0;
      rdout_dpram_run     <= 1'b0;
      dpram_len           <= '0;
      evt_cnt             <= '0;
      trunc_err           <= 1'b0;
    end else begin
      rdout_dpram_wren <= pop && !full;
      rdout_dpram_run  <= (state == S_HANDOFF);

      if (pop && !full) begin
        rdout_dpram_wr_addr <= wr_ptr[ADDR_W-1:0];
        rdout_dpram_data    <= src_data;
      end

      if (fill_entry) begin
        wr_ptr      <= '0;
        evt_in_buf  <= '0;
        at_boundary <= 1'b0;
      end else if (pop) begin
        wr_ptr      <= ptr_after;
        at_boundary <= src_last && pack_continue;
        if (src_last) evt_in_buf <= evt_in_buf + 16'd1;
      end

      // HANDOFF lasts one cycle so the final write lands before run is raised.
      if (state == S_HANDOFF) begin
        dpram_len <= 16'(wr_ptr) << LEN_UNIT_SHIFT;
        evt_cnt   <= evt_cnt + evt_in_buf;
      end

      if (pop && full)  trunc_err <= 1'b1;
      else if (err_clr) trunc_err <= 1'b0;
    end
  end

endmodule
